// File: rtl/alu_pkg.sv
// Shared opcode, status-code and width definitions for the calculator accumulator ALU.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 4;

  localparam logic [3:0] OP_HOLD = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MOD  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_CLR  = 4'b1100;
  localparam logic [3:0] OP_LOAD = 4'b1101;
  localparam logic [3:0] OP_ILL  = 4'b1110;
  localparam logic [3:0] OP_POW  = 4'b1111;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

endpackage

// File: rtl/alu_power.sv
// Combinational unsigned base_i^exp_i by square-and-multiply over every exponent bit.
// Zero latency, no flow control; ovf_o flags a true result of 2^WIDTH or more.
module alu_power #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] exp_i,
  output logic [WIDTH-1:0] pow_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   sq;
  logic [2*WIDTH-1:0] prod;
  logic               sq_big;
  logic               ovf;

  // Values are kept modulo 2^WIDTH so the low bits stay exact after an overflow.
  // A squared base that has outgrown WIDTH only matters once a later exponent bit uses it.
  always_comb begin
    res    = {{(WIDTH-1){1'b0}}, 1'b1};
    sq     = base_i;
    prod   = '0;
    sq_big = 1'b0;
    ovf    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (exp_i[i]) begin
        prod = {{WIDTH{1'b0}}, res} * {{WIDTH{1'b0}}, sq};
        if (sq_big || (prod[2*WIDTH-1:WIDTH] != '0)) ovf = 1'b1;
        res = prod[WIDTH-1:0];
      end
      prod = {{WIDTH{1'b0}}, sq} * {{WIDTH{1'b0}}, sq};
      if (prod[2*WIDTH-1:WIDTH] != '0) sq_big = 1'b1;
      sq = prod[WIDTH-1:0];
    end
    pow_o = res;
    ovf_o = ovf;
  end

endmodule

// File: rtl/alu.sv
// Accumulator ALU: each rising clk applies opCode to acc/inputP/inputQ and stores the result.
// One-cycle latency, accepts an op every cycle; errorCode reports the status of the last op.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inputP,
  input  logic [WIDTH-1:0] inputQ,
  input  logic [OPW-1:0]   opCode,
  output logic [WIDTH-1:0] outALU,
  output logic [1:0]       errorCode
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [1:0]         err_q, err_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   pow_val;
  logic               pow_ovf;
  logic [SHW-1:0]     shamt;

  alu_power #(.WIDTH(WIDTH)) u_power (
    .base_i (inputP),
    .exp_i  (inputQ),
    .pow_o  (pow_val),
    .ovf_o  (pow_ovf)
  );

  assign sum   = {1'b0, acc_q} + {1'b0, inputP};
  assign diff  = {1'b0, acc_q} - {1'b0, inputP};
  assign prod  = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, inputP};
  assign shamt = inputQ[SHW-1:0];

  always_comb begin
    acc_d = acc_q;
    err_d = ERR_OK;
    case (opCode)
      OP_HOLD: acc_d = acc_q;
      OP_ADD: begin
        acc_d = sum[WIDTH-1:0];
        if (sum[WIDTH]) err_d = ERR_OVF;
      end
      OP_MUL: begin
        acc_d = prod[WIDTH-1:0];
        if (prod[2*WIDTH-1:WIDTH] != '0) err_d = ERR_OVF;
      end
      OP_DIV: begin
        if (inputP == '0) err_d = ERR_DIV0;
        else              acc_d = acc_q / inputP;
      end
      OP_SUB: begin
        acc_d = diff[WIDTH-1:0];
        if (diff[WIDTH]) err_d = ERR_OVF;
      end
      OP_MOD: begin
        if (inputP == '0) err_d = ERR_DIV0;
        else              acc_d = acc_q % inputP;
      end
      OP_AND:  acc_d = acc_q & inputP;
      OP_OR:   acc_d = acc_q | inputP;
      OP_XOR:  acc_d = acc_q ^ inputP;
      OP_NOT:  acc_d = ~acc_q;
      OP_SHL:  acc_d = acc_q << shamt;
      OP_SHR:  acc_d = acc_q >> shamt;
      OP_CLR:  acc_d = '0;
      OP_LOAD: acc_d = inputP;
      OP_ILL:  err_d = ERR_ILL;
      OP_POW: begin
        acc_d = pow_val;
        if (pow_ovf) err_d = ERR_OVF;
      end
      default: err_d = ERR_ILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      err_q <= ERR_OK;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign outALU    = acc_q;
  assign errorCode = err_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the accumulator ALU with hand-computed expectations.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] inputP;
  logic [31:0] inputQ;
  logic [3:0]  opCode;
  logic [31:0] outALU;
  logic [1:0]  errorCode;

  int n_checks;
  int n_fail;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .inputP    (inputP),
    .inputQ    (inputQ),
    .opCode    (opCode),
    .outALU    (outALU),
    .errorCode (errorCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one op at the falling edge, then sample 1 time unit after the rising edge.
  task automatic op(input logic [3:0] code, input logic [31:0] p, input logic [31:0] q,
                    input logic [31:0] exp_acc, input logic [1:0] exp_err, input string tag);
    @(negedge clk);
    opCode = code;
    inputP = p;
    inputQ = q;
    @(posedge clk);
    #1;
    check({tag, ".acc"}, outALU, exp_acc);
    check({tag, ".err"}, {30'd0, errorCode}, {30'd0, exp_err});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst    = 1'b1;
    opCode = 4'b0000;
    inputP = 32'd0;
    inputQ = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.acc", outALU, 32'd0);
    check("reset.err", {30'd0, errorCode}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-cycle clears a non-zero acc and error immediately
    op(4'b1101, 32'd42, 32'd0, 32'd42, 2'b00, "load42");
    op(4'b1110, 32'd7,  32'd0, 32'd42, 2'b11, "ill_pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.acc", outALU, 32'd0);
    check("async_rst.err", {30'd0, errorCode}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sphere volume chain
    op(4'b1100, 32'd0,    32'd0, 32'd0,       2'b00, "clear");
    op(4'b1111, 32'd5,    32'd3, 32'd125,     2'b00, "pow5_3");
    op(4'b0010, 32'd3141, 32'd0, 32'd392625,  2'b00, "mul3141");
    op(4'b0010, 32'd4,    32'd0, 32'd1570500, 2'b00, "mul4");
    op(4'b0011, 32'd3000, 32'd0, 32'd523,     2'b00, "div3000");

    // Divide / modulo by zero
    op(4'b0011, 32'd0,  32'd0, 32'd523, 2'b10, "div0");
    op(4'b0000, 32'd0,  32'd0, 32'd523, 2'b00, "hold");
    op(4'b0101, 32'd0,  32'd0, 32'd523, 2'b10, "mod0");
    op(4'b0101, 32'd10, 32'd0, 32'd3,   2'b00, "mod10");

    // Overflow and power boundaries
    op(4'b1101, 32'hFFFF_FFFF, 32'd0,    32'hFFFF_FFFF, 2'b00, "loadmax");
    op(4'b0001, 32'd1,         32'd0,    32'd0,         2'b01, "add_ovf");
    op(4'b0001, 32'd5,         32'd0,    32'd5,         2'b00, "add");
    op(4'b1101, 32'h0001_0000, 32'd0,    32'h0001_0000, 2'b00, "load64k");
    op(4'b0010, 32'h0001_0000, 32'd0,    32'd0,         2'b01, "mul_ovf");
    op(4'b1101, 32'h0000_FFFF, 32'd0,    32'h0000_FFFF, 2'b00, "loadffff");
    op(4'b0010, 32'h0001_0001, 32'd0,    32'hFFFF_FFFF, 2'b00, "mul_edge");
    op(4'b1111, 32'd2,         32'd32,   32'd0,         2'b01, "pow2_32");
    op(4'b1111, 32'd2,         32'd31,   32'h8000_0000, 2'b00, "pow2_31");
    op(4'b1111, 32'd1,         32'd1000, 32'd1,         2'b00, "pow1_1000");
    op(4'b1111, 32'd0,         32'd0,    32'd1,         2'b00, "pow0_0");
    op(4'b1111, 32'd0,         32'd5,    32'd0,         2'b00, "pow0_5");
    op(4'b1111, 32'd3,         32'd20,   32'hCFD4_1B91, 2'b00, "pow3_20");
    op(4'b1111, 32'd3,         32'd21,   32'h6F7C_52B3, 2'b01, "pow3_21");

    // Subtract, logic and shifts
    op(4'b1101, 32'd10,    32'd0,  32'd10,          2'b00, "load10");
    op(4'b0100, 32'd3,     32'd0,  32'd7,           2'b00, "sub3");
    op(4'b0100, 32'd8,     32'd0,  32'hFFFF_FFFF,   2'b01, "sub_borrow");
    op(4'b1101, 32'hF0,    32'd0,  32'hF0,          2'b00, "loadF0");
    op(4'b1010, 32'd0,     32'd4,  32'hF00,         2'b00, "shl4");
    op(4'b1011, 32'd0,     32'd8,  32'hF,           2'b00, "shr8");
    op(4'b1000, 32'hFF,    32'd0,  32'hF0,          2'b00, "xorFF");
    op(4'b1001, 32'd0,     32'd0,  32'hFFFF_FF0F,   2'b00, "not");
    op(4'b0110, 32'h0F,    32'd0,  32'h0F,          2'b00, "and");
    op(4'b0111, 32'h100,   32'd0,  32'h10F,         2'b00, "or");
    op(4'b1101, 32'd1,     32'd0,  32'd1,           2'b00, "load1");
    op(4'b1010, 32'd0,     32'd36, 32'h10,          2'b00, "shl_q36");

    // Illegal opcode leaves acc alone
    op(4'b1101, 32'd42, 32'd0, 32'd42, 2'b00, "load42b");
    op(4'b1110, 32'd99, 32'd3, 32'd42, 2'b11, "illegal");
    op(4'b0000, 32'd0,  32'd0, 32'd42, 2'b00, "hold_after_ill");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
